// File: rtl/n64_pkg.sv
// Shared N64 line timing constants and the bit-recovery FSM state type.
package n64_pkg;

    localparam int BIT_CELL_US     = 4;
    localparam int SHORT_PHASE_US  = 1;
    localparam int LONG_PHASE_US   = 3;
    localparam int CLKS_PER_US_DEF = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURE   = 2'd1,
        WAIT_HIGH = 2'd2
    } n64_state_e;

endpackage

// File: rtl/n64_async_to_sync_if.sv
// Pad-side view of the N64 line: raw data in, decoded bit and bit strobe out.
interface n64_async_to_sync_if;

    logic data;
    logic derived_signal;
    logic derived_clk;

    modport master (
        output data,
        input  derived_signal,
        input  derived_clk
    );

    modport slave (
        input  data,
        output derived_signal,
        output derived_clk
    );

endinterface

// File: rtl/n64_sync_edge.sv
// Two-flop synchroniser for the raw N64 line plus falling-edge detection.
module n64_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic data_i,
    output logic sync_o,
    output logic fall_o
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [2:0] vld_q,  vld_d;

    // vld_q[n] marks that stage n holds a real line sample rather than its reset value,
    // so a line already low when reset is released is not mistaken for a fall.
    always_comb begin
        meta_d = data_i;
        sync_d = meta_q;
        prev_d = sync_q;
        vld_d  = {vld_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            vld_q  <= 3'b000;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = vld_q[2] & prev_q & ~sync_q;

endmodule

// File: rtl/n64_async_to_sync.sv
// Recovers N64 line bits by sampling a fixed time after each falling edge and
// emits the bit value with a strobe that rises one cycle after the value settles.
module n64_async_to_sync
    import n64_pkg::*;
#(
    parameter int CLKS_PER_US = CLKS_PER_US_DEF,
    parameter int SAMPLE_AT   = 2 * CLKS_PER_US,
    parameter int PULSE_LEN   = CLKS_PER_US,
    parameter int STUCK_LIMIT = 8 * CLKS_PER_US
) (
    input  logic                      sample_clk,
    input  logic                      rst_n,
    n64_async_to_sync_if.slave        bus
);

    localparam int CNT_W   = $clog2(STUCK_LIMIT + 1);
    localparam int PULSE_W = $clog2(PULSE_LEN + 1);

    localparam logic [CNT_W-1:0]   SAMPLE_C = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0]   STUCK_C  = CNT_W'(STUCK_LIMIT);
    localparam logic [PULSE_W-1:0] PULSE_C  = PULSE_W'(PULSE_LEN);

    logic sync;
    logic fall;

    n64_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               sig_q,   sig_d;
    logic               start_q, start_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == STUCK_C) ? v : v + CNT_W'(1);
    endfunction

    n64_sync_edge u_sync_edge (
        .clk    (sample_clk),
        .rst_n  (rst_n),
        .data_i (bus.data),
        .sync_o (sync),
        .fall_o (fall)
    );

    // A rise before the sample point is ignored: '1' bits are recognised by reading
    // high at SAMPLE_AT, not by the edge itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEASURE: begin
                cnt_d = sat_inc(cnt_q);
                if (cnt_q == SAMPLE_C) begin
                    sig_d   = sync;
                    start_d = 1'b1;
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (sync) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe counter runs on its own so a new bit can start while a pulse finishes.
    always_comb begin
        pulse_d = pulse_q;
        if (start_q) begin
            pulse_d = PULSE_C;
        end else if (pulse_q != '0) begin
            pulse_d = pulse_q - PULSE_W'(1);
        end
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= 1'b1;
            start_q <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            start_q <= start_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.derived_signal = sig_q;
    assign bus.derived_clk    = (pulse_q != '0);

endmodule

// File: tb/tb_n64_async_to_sync.sv
// Scoreboard bench: stimulus queues expected bit values, a monitor checks each strobe.
module tb_n64_async_to_sync;
    import n64_pkg::*;

    localparam int CPU       = CLKS_PER_US_DEF;
    localparam int PULSE_LEN = CPU;
    localparam int CELL      = BIT_CELL_US * CPU;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];

    n64_async_to_sync_if bus ();

    n64_async_to_sync #(.CLKS_PER_US(CPU)) dut (
        .sample_clk (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        bus.data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Low phase then high phase; the line value at the 2 us point decides the bit.
    task automatic send_low(input int low_c, input int high_c, input bit expect_bit);
        exp_q.push_back(expect_bit);
        bus.data = 1'b0;
        repeat (low_c) @(negedge clk);
        bus.data = 1'b1;
        repeat (high_c) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        int low_c;
        low_c = (b ? SHORT_PHASE_US : LONG_PHASE_US) * CPU;
        send_low(low_c, CELL - low_c, b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin : monitor
        logic pclk, psig, rsig;
        int   width;
        bit   stable;
        pclk = 1'b0; psig = 1'b1; rsig = 1'b1; width = 0; stable = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pclk  = 1'b0;
                width = 0;
                psig  = bus.derived_signal;
                continue;
            end
            if (bus.derived_clk === 1'b1 && !pclk) begin
                check("sig_setup", bus.derived_signal, psig);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got strobe with value %0d required no strobe",
                             bus.derived_signal);
                end else begin
                    check("bit_value", bus.derived_signal, exp_q.pop_front());
                end
                rsig   = bus.derived_signal;
                width  = 1;
                stable = 1'b1;
            end else if (bus.derived_clk === 1'b1) begin
                width++;
                if (bus.derived_signal !== rsig) stable = 1'b0;
            end else if (pclk) begin
                check("pulse_width", width, PULSE_LEN);
                check("sig_hold", stable, 1);
            end
            pclk = (bus.derived_clk === 1'b1);
            psig = bus.derived_signal;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end of run required finish within time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int nbits;
        bus.data = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sig", bus.derived_signal, 1);
        check("reset_clk", bus.derived_clk, 0);
        for (int i = 0; i < 8; i++) begin
            bus.data = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_hold_sig", bus.derived_signal, 1);
            check("reset_hold_clk", bus.derived_clk, 0);
        end
        bus.data = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        send_bit(1'b1);
        idle(12);
        send_bit(1'b0);
        idle(12);

        // Console poll 0x01 followed by its stop bit.
        send_byte(8'h01);
        send_bit(1'b1);
        idle(12);

        // Line held low for 20 us, then released, then an ordinary '1'.
        send_low(20 * CPU, 4, 1'b0);
        send_bit(1'b1);
        idle(12);

        // Controller stop bit: 2 us low reads high at the sample point.
        send_low(2 * CPU, 3 * CPU, 1'b1);
        idle(8);

        for (int f = 0; f < 10; f++) begin
            nbits = $urandom_range(1, 16);
            for (int b = 0; b < nbits; b++) send_bit(1'($urandom_range(0, 1)));
            idle($urandom_range(0, 10));
        end
        idle(12);

        // Reset 1 us into a '0' bit, released while the line is still low.
        bus.data = 1'b0;
        repeat (SHORT_PHASE_US * CPU) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midbit_reset_sig", bus.derived_signal, 1);
        check("midbit_reset_clk", bus.derived_clk, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        idle(14);
        check("no_pulse_after_reset", exp_q.size(), 0);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(16);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
